alu_multiciclo: RTL and testbench
=================================

Name: alu_multiciclo

Overview:
Parametrised multi-cycle RV32I/M execution unit. It merges ALU-control decode (modo/funct3/funct7 -> sel_alu) with a registered datapath that adds iterative shifts and shift-add multiplication (MUL/MULH/MULHSU/MULHU). It sits between the main control FSM of the multicycle core and the register-file write-back. It uses an inicio/listo handshake so the core stalls while ocupado=1.

Parameters:
ANCHO, 32, operand/result width in bits (power of 2, >=8)
PASO_DESP, 1, bits shifted per cycle in serial shifts (power of 2, 1..ANCHO)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
inicio  in  1  start request, sampled only when ocupado=0
modo  in  2  00 SUMA only, 01 opcode 0010011, 10 opcode 0110011, 11 branches (1100011)
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7 (bit5 = SUB/SRA, value 0000001 = M-extension)
op_a  in  ANCHO  operand A (rs1)
op_b  in  ANCHO  operand B (rs2 or immediate)
resultado  out  ANCHO  registered result, valid while listo=1
cero  out  1  resultado==0, valid with listo
tomar_salto  out  1  branch condition, valid with listo when modo=11, else 0
error_op  out  1  unsupported op (DIV/REM), valid with listo
ocupado  out  1  operation in progress
listo  out  1  one-cycle completion pulse
sel_alu  out  4  decoded operation, combinational from inputs

Behaviour:
- Reset: all outputs 0; FSM to REPOSO; internal operand/accumulator registers cleared. Reset mid-operation aborts the operation with no listo pulse.
- sel_alu encoding (package): SUMA 0, RESTA 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL A, MULH B, MULHSU C, MULHU D, INVAL F.
- Decode rules:
  - modo 00 -> SUMA.
  - modo 01: funct3 000 -> SUMA always (no SUBI). 101 -> SRA if funct7[5] else SRL. The other funct3 values map as in R-type.
  - modo 10: funct7=0000001 selects M-ext (funct3 000..011 -> MUL..MULHU; 100..111 -> INVAL). Otherwise funct3 000 -> RESTA if funct7[5] else SUMA, and 101 -> SRA/SRL by funct7[5].
  - modo 11: 000/001 -> RESTA; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> INVAL.
- FSM states: REPOSO, DESPLAZA, MULTIPLICA, FIN.
- REPOSO with inicio=1: latch op_a, op_b, sel_alu and funct3, then set ocupado=1.
  - Single-cycle ops (SUMA..SLTU, XOR, OR, AND, INVAL) go to FIN. listo is asserted on the edge after inicio, so latency is 1.
  - Shifts go to DESPLAZA, with shamt = op_b[$clog2(ANCHO)-1:0].
  - MUL* goes to MULTIPLICA.
- DESPLAZA:
  - Each cycle shift by min(PASO_DESP, remaining) and decrement remaining.
  - Exit to FIN when remaining reaches 0.
  - Latency = ceil(shamt/PASO_DESP)+1. shamt=0 gives latency 1.
  - SRA replicates the sign bit.
- MULTIPLICA:
  - Radix-2 shift-add on the unsigned magnitudes into a 2*ANCHO accumulator over ANCHO cycles.
  - Signed variants negate the final product when the operand signs differ. MULH treats both operands as signed; MULHSU treats A as signed and B as unsigned.
  - MUL returns the low ANCHO bits; the MULH* variants return the high ANCHO bits.
  - Latency = ANCHO+1.
- FIN:
  - listo=1 and resultado, cero, tomar_salto and error_op are updated for exactly this one cycle.
  - ocupado drops in the same cycle, and the FSM returns to REPOSO.
  - resultado holds its value until the next completion.
- inicio while ocupado=1 is ignored, with no queueing. inicio in the FIN cycle is also ignored.
- tomar_salto by funct3:
  - BEQ: cero.
  - BNE: !cero.
  - BLT/BLTU: resultado[0].
  - BGE/BGEU: !resultado[0].
- INVAL: resultado=0 and error_op=1.
- Wrap-around: SUMA/RESTA are modulo 2^ANCHO, with no overflow flag.

Decomposition:
- Package alu_pkg: sel_alu localparams, modo localparams (MODO_SUMA, MODO_I, MODO_R, MODO_B), FSM state encoding, funct7 constants F7_BASE/F7_ALT/F7_MEXT.
- One sub-module: decodificador_alu, the combinational modo/funct3/funct7 -> sel_alu decode, reused by the core control unit. The FSM and datapath stay in alu_multiciclo.

Test Plan:
- Test 1: rst=1 for 2 cycles mid-MUL (op_a=5, op_b=7, cycle 10). Required: no listo; all outputs 0; next inicio works normally.
- Test 2: modo=10, funct7=0100000, funct3=000, op_a=5, op_b=7. Required: sel_alu=1; listo 1 cycle after inicio; resultado=32'hFFFFFFFE; cero=0.
- Test 3: modo=01, funct3=101, funct7[5]=1, op_a=32'h80000000, op_b=4, PASO_DESP=1. Required: resultado=32'hF8000000; listo 5 cycles after inicio.
- Test 4: modo=10, funct7=0000001, funct3=001 (MULH), op_a=-3, op_b=7. Required: resultado=32'hFFFFFFFF after 33 cycles.
- Test 5: modo=10, funct3=000 (MUL) with op_a=op_b=32'hFFFFFFFF. Required: resultado=1. Then rerun with funct3=011 (MULHU) on the same operands. Required: resultado=32'hFFFFFFFE.
- Test 6: modo=11, BGEU (funct3=111), op_a=1, op_b=2. Required: tomar_salto=0.
- Test 7: modo=11, BEQ (funct3=000), op_a=op_b=9. Required: tomar_salto=1.
- Test 8: modo=10, funct7=0000001, funct3=100. Required: error_op=1; resultado=0.
- Test 9: second inicio while ocupado=1. Required: ignored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle RV32I/M execution unit:
// operation codes (sel_alu), modo codes, funct7 constants, FSM states and helpers.
package alu_pkg;

    // Decoded operation codes
    localparam logic [3:0] SEL_SUMA   = 4'h0;
    localparam logic [3:0] SEL_RESTA  = 4'h1;
    localparam logic [3:0] SEL_SLL    = 4'h2;
    localparam logic [3:0] SEL_SLT    = 4'h3;
    localparam logic [3:0] SEL_SLTU   = 4'h4;
    localparam logic [3:0] SEL_XOR    = 4'h5;
    localparam logic [3:0] SEL_SRL    = 4'h6;
    localparam logic [3:0] SEL_SRA    = 4'h7;
    localparam logic [3:0] SEL_OR     = 4'h8;
    localparam logic [3:0] SEL_AND    = 4'h9;
    localparam logic [3:0] SEL_MUL    = 4'hA;
    localparam logic [3:0] SEL_MULH   = 4'hB;
    localparam logic [3:0] SEL_MULHSU = 4'hC;
    localparam logic [3:0] SEL_MULHU  = 4'hD;
    localparam logic [3:0] SEL_INVAL  = 4'hF;

    // Instruction class driven by the main control FSM
    localparam logic [1:0] MODO_SUMA = 2'b00;
    localparam logic [1:0] MODO_I    = 2'b01;
    localparam logic [1:0] MODO_R    = 2'b10;
    localparam logic [1:0] MODO_B    = 2'b11;

    // funct7 values of interest
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        REPOSO     = 2'd0,
        DESPLAZA   = 2'd1,
        MULTIPLICA = 2'd2,
        FIN        = 2'd3
    } estado_t;

    function automatic logic es_desplazamiento(input logic [3:0] sel);
        return (sel == SEL_SLL) || (sel == SEL_SRL) || (sel == SEL_SRA);
    endfunction

    function automatic logic es_multiplicacion(input logic [3:0] sel);
        return (sel >= SEL_MUL) && (sel <= SEL_MULHU);
    endfunction

endpackage

// File: rtl/alu_multiciclo_decodificador.sv
// ALU-control decode: modo/funct3/funct7 -> sel_alu (purely combinational).
// Ports: modo, funct3, funct7 in; sel_alu out.
module decodificador_alu
    import alu_pkg::*;
(
    input  logic [1:0] modo,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] sel_alu
);

    logic [3:0] sel_base;

    // Base integer mapping shared by I- and R-type
    always_comb begin
        sel_base = SEL_INVAL;
        case (funct3)
            3'b000: sel_base = SEL_SUMA;
            3'b001: sel_base = SEL_SLL;
            3'b010: sel_base = SEL_SLT;
            3'b011: sel_base = SEL_SLTU;
            3'b100: sel_base = SEL_XOR;
            3'b101: sel_base = funct7[5] ? SEL_SRA : SEL_SRL;
            3'b110: sel_base = SEL_OR;
            3'b111: sel_base = SEL_AND;
        endcase
    end

    always_comb begin
        sel_alu = SEL_SUMA;
        case (modo)
            MODO_SUMA: sel_alu = SEL_SUMA;
            MODO_I:    sel_alu = sel_base;
            MODO_R: begin
                if (funct7 == F7_MEXT)
                    sel_alu = funct3[2] ? SEL_INVAL : (SEL_MUL + {2'b00, funct3[1:0]});
                else if ((funct3 == 3'b000) && funct7[5])
                    sel_alu = SEL_RESTA;
                else
                    sel_alu = sel_base;
            end
            MODO_B: begin
                case (funct3[2:1])
                    2'b00: sel_alu = SEL_RESTA;
                    2'b01: sel_alu = SEL_INVAL;
                    2'b10: sel_alu = SEL_SLT;
                    2'b11: sel_alu = SEL_SLTU;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle RV32I/M execution unit: single-cycle ALU ops, serial shifts and
// radix-2 shift-add multiplication behind an inicio/listo handshake.
// Ports: clk, rst (sync, active-high), inicio, modo, funct3, funct7, op_a, op_b in;
//        resultado, cero, tomar_salto, error_op, ocupado, listo (registered),
//        sel_alu (combinational decode) out.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int unsigned ANCHO     = 32,
    parameter int unsigned PASO_DESP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [1:0]       modo,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [ANCHO-1:0] op_a,
    input  logic [ANCHO-1:0] op_b,
    output logic [ANCHO-1:0] resultado,
    output logic             cero,
    output logic             tomar_salto,
    output logic             error_op,
    output logic             ocupado,
    output logic             listo,
    output logic [3:0]       sel_alu
);

    localparam int unsigned LOG = $clog2(ANCHO);
    localparam int unsigned CW  = LOG + 1;
    localparam logic [CW-1:0] PASO       = CW'(PASO_DESP);
    localparam logic [CW-1:0] CICLOS_MUL = CW'(ANCHO);

    decodificador_alu u_decodificador (
        .modo    (modo),
        .funct3  (funct3),
        .funct7  (funct7),
        .sel_alu (sel_alu)
    );

    estado_t             estado_q, estado_d;
    logic [ANCHO-1:0]    a_q;       // shift operand, or multiplicand magnitude
    logic [2*ANCHO-1:0]  acc_q;     // {partial product, remaining multiplier bits}
    logic [CW-1:0]       cnt_q;     // remaining shift amount / multiply steps
    logic [3:0]          sel_q;
    logic [2:0]          f3_q;
    logic                salto_q;
    logic                neg_q;

    logic                termina;
    logic [ANCHO-1:0]    res_fin;
    logic                cero_c;
    logic [3:0]          sel_act;
    logic [2:0]          f3_act;
    logic                salto_act;
    logic                cond_salto;
    logic [CW-1:0]       paso;
    logic [ANCHO-1:0]    desp_sig;
    logic [ANCHO:0]      suma_mul;
    logic [2*ANCHO-1:0]  acc_sig;
    logic [2*ANCHO-1:0]  producto;
    logic [ANCHO-1:0]    res_mul;
    logic                a_neg, b_neg;
    logic [ANCHO-1:0]    mag_a, mag_b;

    function automatic logic [ANCHO-1:0] alu_simple(input logic [3:0] sel,
                                                    input logic [ANCHO-1:0] a,
                                                    input logic [ANCHO-1:0] b);
        case (sel)
            SEL_SUMA:  return a + b;
            SEL_RESTA: return a - b;
            SEL_SLT:   return ANCHO'($signed(a) < $signed(b));
            SEL_SLTU:  return ANCHO'(a < b);
            SEL_XOR:   return a ^ b;
            SEL_OR:    return a | b;
            SEL_AND:   return a & b;
            default:   return '0;
        endcase
    endfunction

    // Operand magnitudes and product sign for the multiplier
    always_comb begin
        a_neg = op_a[ANCHO-1] & ((sel_alu == SEL_MULH) || (sel_alu == SEL_MULHSU));
        b_neg = op_b[ANCHO-1] & (sel_alu == SEL_MULH);
        mag_a = a_neg ? -op_a : op_a;
        mag_b = b_neg ? -op_b : op_b;
    end

    // One serial-shift step and one shift-add step
    always_comb begin
        paso = (cnt_q < PASO) ? cnt_q : PASO;
        case (sel_q)
            SEL_SLL: desp_sig = a_q << paso;
            SEL_SRA: desp_sig = ANCHO'($signed(a_q) >>> paso);
            default: desp_sig = a_q >> paso;
        endcase
        suma_mul = {1'b0, acc_q[2*ANCHO-1:ANCHO]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_sig  = {suma_mul, acc_q[ANCHO-1:1]};
        producto = neg_q ? -acc_sig : acc_sig;
        res_mul  = (sel_q == SEL_MUL) ? producto[ANCHO-1:0] : producto[2*ANCHO-1:ANCHO];
    end

    // Next-state and completion decode
    always_comb begin
        estado_d = estado_q;
        termina  = 1'b0;
        res_fin  = '0;
        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    if (es_multiplicacion(sel_alu)) begin
                        estado_d = MULTIPLICA;
                    end else if (es_desplazamiento(sel_alu) && (op_b[LOG-1:0] != '0)) begin
                        estado_d = DESPLAZA;
                    end else begin
                        estado_d = FIN;
                        termina  = 1'b1;
                        res_fin  = es_desplazamiento(sel_alu) ? op_a
                                                              : alu_simple(sel_alu, op_a, op_b);
                    end
                end
            end
            DESPLAZA: begin
                if (cnt_q <= PASO) begin
                    estado_d = FIN;
                    termina  = 1'b1;
                    res_fin  = desp_sig;
                end
            end
            MULTIPLICA: begin
                if (cnt_q == CW'(1)) begin
                    estado_d = FIN;
                    termina  = 1'b1;
                    res_fin  = res_mul;
                end
            end
            FIN: estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    // Flags follow the live inputs for single-cycle ops, latched ones otherwise
    always_comb begin
        sel_act   = (estado_q == REPOSO) ? sel_alu : sel_q;
        f3_act    = (estado_q == REPOSO) ? funct3 : f3_q;
        salto_act = (estado_q == REPOSO) ? (modo == MODO_B) : salto_q;
        cero_c    = (res_fin == '0);
        case (f3_act)
            3'b000:         cond_salto = cero_c;
            3'b001:         cond_salto = !cero_c;
            3'b100, 3'b110: cond_salto = res_fin[0];
            3'b101, 3'b111: cond_salto = !res_fin[0];
            default:        cond_salto = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) estado_q <= REPOSO;
        else     estado_q <= estado_d;
    end

    // Operand/accumulator registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            f3_q        <= '0;
            salto_q     <= 1'b0;
            neg_q       <= 1'b0;
            resultado   <= '0;
            cero        <= 1'b0;
            tomar_salto <= 1'b0;
            error_op    <= 1'b0;
            ocupado     <= 1'b0;
            listo       <= 1'b0;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (inicio) begin
                        sel_q   <= sel_alu;
                        f3_q    <= funct3;
                        salto_q <= (modo == MODO_B);
                        neg_q   <= a_neg ^ b_neg;
                        a_q     <= es_multiplicacion(sel_alu) ? mag_a : op_a;
                        acc_q   <= {{ANCHO{1'b0}}, mag_b};
                        cnt_q   <= es_multiplicacion(sel_alu) ? CICLOS_MUL : CW'(op_b[LOG-1:0]);
                    end
                end
                DESPLAZA: begin
                    a_q   <= desp_sig;
                    cnt_q <= cnt_q - paso;
                end
                MULTIPLICA: begin
                    acc_q <= acc_sig;
                    cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase

            listo   <= termina;
            ocupado <= (estado_d == DESPLAZA) || (estado_d == MULTIPLICA);
            if (termina) begin
                resultado   <= res_fin;
                cero        <= cero_c;
                error_op    <= (sel_act == SEL_INVAL);
                tomar_salto <= salto_act & cond_salto;
            end else begin
                cero        <= 1'b0;
                error_op    <= 1'b0;
                tomar_salto <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed cases plus random ops,
// expectations queued at issue time and checked by an independent monitor.
module tb_alu_multiciclo;
    import alu_pkg::*;

    localparam int unsigned ANCHO     = 32;
    localparam int unsigned PASO_DESP = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inicio = 1'b0;
    logic [1:0]       modo = '0;
    logic [2:0]       funct3 = '0;
    logic [6:0]       funct7 = '0;
    logic [ANCHO-1:0] op_a = '0;
    logic [ANCHO-1:0] op_b = '0;
    logic [ANCHO-1:0] resultado;
    logic             cero, tomar_salto, error_op, ocupado, listo;
    logic [3:0]       sel_alu;

    alu_multiciclo #(.ANCHO(ANCHO), .PASO_DESP(PASO_DESP)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .modo(modo), .funct3(funct3),
        .funct7(funct7), .op_a(op_a), .op_b(op_b), .resultado(resultado),
        .cero(cero), .tomar_salto(tomar_salto), .error_op(error_op),
        .ocupado(ocupado), .listo(listo), .sel_alu(sel_alu)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        cero;
        logic        salto;
        logic        err;
        int unsigned lat;
        int unsigned t0;
    } esperado_t;

    esperado_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    // Reference decode, written from the instruction tables
    function automatic logic [3:0] ref_sel(input logic [1:0] m, input logic [2:0] f3,
                                           input logic [6:0] f7);
        if (m == 2'b00) return SEL_SUMA;
        if (m == 2'b11) begin
            if (f3 <= 3'd1) return SEL_RESTA;
            if (f3 <= 3'd3) return SEL_INVAL;
            if (f3 <= 3'd5) return SEL_SLT;
            return SEL_SLTU;
        end
        if (m == 2'b10 && f7 == 7'h01) begin
            if (f3 >= 3'd4) return SEL_INVAL;
            return 4'(SEL_MUL + 4'(f3));
        end
        case (f3)
            3'd0:    return (m == 2'b10 && f7[5]) ? SEL_RESTA : SEL_SUMA;
            3'd1:    return SEL_SLL;
            3'd2:    return SEL_SLT;
            3'd3:    return SEL_SLTU;
            3'd4:    return SEL_XOR;
            3'd5:    return f7[5] ? SEL_SRA : SEL_SRL;
            3'd6:    return SEL_OR;
            default: return SEL_AND;
        endcase
    endfunction

    // Reference result and latency using wide arithmetic
    task automatic ref_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int unsigned lat);
        logic [63:0] p;
        int unsigned sh;
        sh  = int'(b[4:0]);
        lat = 1;
        p   = '0;
        case (sel)
            SEL_SUMA:  r = a + b;
            SEL_RESTA: r = a - b;
            SEL_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SEL_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            SEL_XOR:   r = a ^ b;
            SEL_OR:    r = a | b;
            SEL_AND:   r = a & b;
            SEL_SLL:   r = a << sh;
            SEL_SRL:   r = a >> sh;
            SEL_SRA:   r = 32'($signed(a) >>> sh);
            SEL_MUL, SEL_MULHU: begin
                p = {32'd0, a} * {32'd0, b};
                r = (sel == SEL_MUL) ? p[31:0] : p[63:32];
            end
            SEL_MULH: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                r = p[63:32];
            end
            SEL_MULHSU: begin
                p = 64'(longint'($signed(a)) * longint'({32'd0, b}));
                r = p[63:32];
            end
            default:   r = '0;
        endcase
        if (sel == SEL_SLL || sel == SEL_SRL || sel == SEL_SRA)
            lat = (sh == 0) ? 1 : (sh + PASO_DESP - 1) / PASO_DESP + 1;
        if (sel >= SEL_MUL && sel <= SEL_MULHU)
            lat = ANCHO + 1;
    endtask

    // Issue one operation; inicio is held for 'hold' cycles (extra cycles must be ignored)
    task automatic emitir(input logic [1:0] m, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        esperado_t e;
        logic [3:0] s;
        @(negedge clk);
        modo = m; funct3 = f3; funct7 = f7; op_a = a; op_b = b; inicio = 1'b1;
        #1;
        s = ref_sel(m, f3, f7);
        chk("sel_alu", 32'(sel_alu), 32'(s));
        ref_op(s, a, b, e.res, e.lat);
        e.cero  = (e.res == 0);
        e.err   = (s == SEL_INVAL);
        e.salto = 1'b0;
        if (m == 2'b11) begin
            case (f3)
                3'd0:       e.salto = e.cero;
                3'd1:       e.salto = !e.cero;
                3'd4, 3'd6: e.salto = e.res[0];
                3'd5, 3'd7: e.salto = !e.res[0];
                default:    e.salto = 1'b0;
            endcase
        end
        e.t0 = cyc + 1;
        sb.push_back(e);
        repeat (hold) @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic esperar_fin();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d pending results, no listo", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_salidas_cero(input string nombre);
        chk({nombre, "_resultado"}, resultado, 32'd0);
        chk({nombre, "_flags"}, {28'd0, cero, tomar_salto, error_op, listo}, 32'd0);
        chk({nombre, "_ocupado"}, 32'(ocupado), 32'd0);
    endtask

    // Monitor: every listo pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        esperado_t e;
        if (!rst && listo) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_listo: got listo=1 expected none, resultado=%h", resultado);
            end else begin
                e = sb.pop_front();
                chk("resultado", resultado, e.res);
                chk("cero", 32'(cero), 32'(e.cero));
                chk("tomar_salto", 32'(tomar_salto), 32'(e.salto));
                chk("error_op", 32'(error_op), 32'(e.err));
                chk("latencia", cyc - e.t0 + 1, e.lat);
                chk("ocupado_en_listo", 32'(ocupado), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] operando_rand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin : estimulo
        logic [6:0] f7r;
        repeat (3) @(negedge clk);
        chk_salidas_cero("reset");
        chk("reset_sel_alu", 32'(sel_alu), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: reset in the middle of a multiply
        modo = MODO_R; funct7 = F7_MEXT; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd7; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (8) @(negedge clk);
        chk("mul_ocupado_antes_reset", 32'(ocupado), 32'd1);
        modo = '0; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_salidas_cero("reset_mid_mul");
        chk("reset_mid_mul_sel", 32'(sel_alu), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk_salidas_cero("post_reset");
        emitir(MODO_R, 3'd0, F7_MEXT, 32'd5, 32'd7, 1);
        esperar_fin();

        // Test 2: SUB wraps
        emitir(MODO_R, 3'd0, F7_ALT, 32'd5, 32'd7, 1);
        esperar_fin();
        // Test 3: SRAI by 4
        emitir(MODO_I, 3'd5, F7_ALT, 32'h80000000, 32'd4, 1);
        esperar_fin();
        // Test 4: MULH -3 * 7
        emitir(MODO_R, 3'd1, F7_MEXT, 32'hFFFFFFFD, 32'd7, 1);
        esperar_fin();
        // Test 5: MUL and MULHU on all-ones
        emitir(MODO_R, 3'd0, F7_MEXT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        esperar_fin();
        emitir(MODO_R, 3'd3, F7_MEXT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        esperar_fin();
        // Test 6/7: BGEU not taken, BEQ taken
        emitir(MODO_B, 3'd7, F7_BASE, 32'd1, 32'd2, 1);
        esperar_fin();
        emitir(MODO_B, 3'd0, F7_BASE, 32'd9, 32'd9, 1);
        esperar_fin();
        // Test 8: DIV is unsupported
        emitir(MODO_R, 3'd4, F7_MEXT, 32'd100, 32'd3, 1);
        esperar_fin();
        // Shift by zero, SUMA mode, MULHSU with negative A
        emitir(MODO_R, 3'd1, F7_BASE, 32'h12345678, 32'd32, 1);
        esperar_fin();
        emitir(MODO_SUMA, 3'd5, F7_ALT, 32'hFFFFFFFF, 32'd1, 1);
        esperar_fin();
        emitir(MODO_R, 3'd2, F7_MEXT, 32'hFFFFFFFE, 32'hFFFFFFFF, 1);
        esperar_fin();

        // Test 9: inicio while busy is ignored
        emitir(MODO_R, 3'd3, F7_MEXT, 32'hDEADBEEF, 32'h12345678, 1);
        repeat (3) begin
            chk("ocupado_durante_mul", 32'(ocupado), 32'd1);
            modo = MODO_SUMA; op_a = 32'd1; op_b = 32'd1; inicio = 1'b1;
            @(negedge clk);
        end
        inicio = 1'b0;
        esperar_fin();
        // inicio still high during the FIN cycle is ignored
        emitir(MODO_R, 3'd4, F7_BASE, 32'hA5A5A5A5, 32'h0F0F0F0F, 2);
        esperar_fin();
        repeat (3) @(negedge clk);

        // Random operations
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       f7r = F7_BASE;
                1:       f7r = F7_ALT;
                2:       f7r = F7_MEXT;
                default: f7r = 7'($urandom());
            endcase
            emitir(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), f7r,
                   operando_rand(), operando_rand(), 1);
            esperar_fin();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
